// File: rtl/fib_req_ctrl_if.sv
// Request/result handshake bundle for the Fibonacci controller.
interface fib_req_ctrl_if #(
  parameter int W     = 16,
  parameter int IDX_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_fib;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_fib, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_fib, out_ovf, busy
  );
endinterface

// File: rtl/fib_req_ctrl.sv
// Computes F(n) mod 2^W on request, iterating one or two Fibonacci steps per cycle,
// with a sticky true-overflow flag and registered valid/ready handshakes.
module fib_req_ctrl #(
  parameter int W           = 16,
  parameter int IDX_W       = 8,
  parameter int DOUBLE_RATE = 0
) (
  input  logic          clk,
  input  logic          rst,
  fib_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO = IDX_W'(2);

  state_e           state_q;
  logic [W-1:0]     a_q, b_q, a_d, b_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_a_q, ovf_b_q, ovf_a_d, ovf_b_d;
  logic             in_ready_q, out_valid_q, out_ovf_q, busy_q;
  logic [W-1:0]     out_fib_q;
  logic [W:0]       sum1;
  logic [W+1:0]     sum2;
  logic             dbl;

  // a tracks F(k), b tracks F(k+1); ovf_* record whether the true value left W bits
  always_comb begin
    sum1    = {1'b0, a_q} + {1'b0, b_q};
    sum2    = {2'b00, a_q} + {1'b0, b_q, 1'b0};
    dbl     = (DOUBLE_RATE != 0) && (cnt_q >= TWO);
    a_d     = b_q;
    b_d     = sum1[W-1:0];
    cnt_d   = cnt_q - ONE;
    ovf_a_d = ovf_b_q;
    ovf_b_d = ovf_a_q | ovf_b_q | sum1[W];
    if (dbl) begin
      a_d     = sum1[W-1:0];
      b_d     = sum2[W-1:0];
      cnt_d   = cnt_q - TWO;
      ovf_a_d = ovf_a_q | ovf_b_q | sum1[W];
      ovf_b_d = ovf_a_q | ovf_b_q | (|sum2[W+1:W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_fib_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= '0;
            b_q        <= W'(1);
            cnt_q      <= bus.in_idx;
            ovf_a_q    <= 1'b0;
            ovf_b_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            out_fib_q   <= a_q;
            out_ovf_q   <= ovf_a_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_fib   = out_fib_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule
